// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_t       - controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH - default operand/result width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle of the bit-serial subtractor.
//   master : drives start, a, b, bi; observes busy, done, d, bo (and ovf)
//   slave  : the subtractor side
// Optional macro SERIAL_SUB_SIGNED_EN adds the signed-overflow flag ovf.
interface serial_sub_if #(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
`ifdef SERIAL_SUB_SIGNED_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
`ifdef SERIAL_SUB_SIGNED_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/full_sub_cell.sv
// full_sub_cell: one-bit full subtractor, purely combinational.
//   a, b, bi : minuend bit, subtrahend bit, borrow in
//   d, bo    : difference bit, borrow out
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, D = A - B - BI, one bit per clock, LSB
// first, WIDTH cycles per operation through a single full_sub_cell.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - serial_sub_if.slave: start/a/b/bi in, busy/done/d/bo(/ovf) out
// Optional macro SERIAL_SUB_SIGNED_EN: adds ovf, two's-complement overflow
// of the operation, valid with done.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_sub_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_d;
    logic             cell_bo;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             ovf_q;
`endif

    full_sub_cell u_cell (
        .a  (sa[0]),
        .b  (sb[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bo_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        br     <= bus.bi;
                        cnt    <= '0;
                        d_q    <= '0;
                        busy_q <= 1'b1;
`ifdef SERIAL_SUB_SIGNED_EN
                        ovf_q  <= 1'b0;
`endif
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    // Result fills from the MSB end so after WIDTH shifts
                    // bit 0 sits in d[0].
                    d_q <= {cell_d, d_q[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= cell_bo;
                    if (cnt == CNT_LAST) begin
                        bo_q   <= cell_bo;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef SERIAL_SUB_SIGNED_EN
                        // br still holds the borrow into the MSB here.
                        ovf_q  <= br ^ cell_bo;
`endif
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
`ifdef SERIAL_SUB_SIGNED_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
